// File: rtl/sel_mux_pipe.sv
// Registered N:1 lane selector with valid/ready handshake, a 2-entry skid buffer and flush.
// Define SEL_MUX_PIPE_PARITY_EN to add out_par, the even parity of the selected lane.
module sel_mux_pipe #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
`ifdef SEL_MUX_PIPE_PARITY_EN
   output logic                    out_par,
`endif
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0] w_selData;
   logic             w_selErr;
   logic             w_accept;
   logic             w_oFree;

   logic             r_oValid;
   logic [WIDTH-1:0] r_oData;
   logic             r_oErr;
   logic             r_sValid;
   logic [WIDTH-1:0] r_sData;
   logic             r_sErr;
   logic             r_inReady;

   // Out-of-range selects yield zero with the error flag rather than X.
   always_comb begin
      w_selData = '0;
      w_selErr  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            w_selData = in_bus[k*WIDTH +: WIDTH];
            w_selErr  = 1'b0;
         end
      end
   end

   assign w_accept = in_valid && r_inReady;
   assign w_oFree  = !r_oValid || out_ready;

   // in_ready is its own flop mirroring "skid empty" so out_ready never reaches it combinationally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_oValid  <= 1'b0;
         r_oData   <= '0;
         r_oErr    <= 1'b0;
         r_sValid  <= 1'b0;
         r_sData   <= '0;
         r_sErr    <= 1'b0;
         r_inReady <= 1'b1;
      end else if (w_oFree && r_sValid) begin
         r_oValid  <= 1'b1;
         r_oData   <= r_sData;
         r_oErr    <= r_sErr;
         r_sValid  <= 1'b0;
         r_inReady <= 1'b1;
      end else if (w_oFree) begin
         r_oValid <= w_accept;
         if (w_accept) begin
            r_oData <= w_selData;
            r_oErr  <= w_selErr;
         end
      end else if (w_accept) begin
         r_sValid  <= 1'b1;
         r_sData   <= w_selData;
         r_sErr    <= w_selErr;
         r_inReady <= 1'b0;
      end
   end

`ifdef SEL_MUX_PIPE_PARITY_EN
   logic w_selPar;
   logic r_oPar;
   logic r_sPar;

   assign w_selPar = ^w_selData;

   // Parity travels with its entry through the same O/S moves as the data.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_oPar <= 1'b0;
         r_sPar <= 1'b0;
      end else if (w_oFree && r_sValid) begin
         r_oPar <= r_sPar;
      end else if (w_oFree) begin
         if (w_accept) begin
            r_oPar <= w_selPar;
         end
      end else if (w_accept) begin
         r_sPar <= w_selPar;
      end
   end

   assign out_par = r_oPar;
`endif

   assign in_ready  = r_inReady;
   assign out_valid = r_oValid;
   assign out_data  = r_oData;
   assign out_err   = r_oErr;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: a 4-lane and a 3-lane instance share one handshake stream and
// are compared every cycle against a 2-deep FIFO model; directed steps pin literal values.
module tb_sel_mux_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] inBus;
   logic [1:0]  sel;
   logic        inValid;
   logic        flush;
   logic        outReady;

   logic        inReady4, outValid4, outErr4;
   logic [4:0]  outData4;
   logic        inReady3, outValid3, outErr3;
   logic [4:0]  outData3;
`ifdef SEL_MUX_PIPE_PARITY_EN
   logic        outPar4, outPar3;
`endif

   int compared = 0;
   int mismatched = 0;

   localparam logic [19:0] LANES = {5'd31, 5'd9, 5'd7, 5'd5};

   always #5 clk = ~clk;

   sel_mux_pipe #(.WIDTH(5), .NUM_IN(4)) dut (
      .clk(clk), .rst(rst), .in_bus(inBus), .sel(sel), .in_valid(inValid),
      .in_ready(inReady4), .flush(flush), .out_data(outData4), .out_err(outErr4),
`ifdef SEL_MUX_PIPE_PARITY_EN
      .out_par(outPar4),
`endif
      .out_valid(outValid4), .out_ready(outReady)
   );

   sel_mux_pipe #(.WIDTH(5), .NUM_IN(3)) dut3 (
      .clk(clk), .rst(rst), .in_bus(inBus[14:0]), .sel(sel), .in_valid(inValid),
      .in_ready(inReady3), .flush(flush), .out_data(outData3), .out_err(outErr3),
`ifdef SEL_MUX_PIPE_PARITY_EN
      .out_par(outPar3),
`endif
      .out_valid(outValid3), .out_ready(outReady)
   );

   // Reference model: entries held in the stage, oldest first, at most two.
   typedef struct {
      logic [19:0] bus;
      logic [1:0]  s;
   } entry_t;

   entry_t q[$];
   bit modelLive = 0;
   bit zeroData = 0;
   bit zeroPar = 0;

   function automatic logic [4:0] pick(input logic [19:0] bus, input logic [1:0] s, input int numIn);
      if (int'(s) >= numIn) return 5'd0;
      return bus[s*5 +: 5];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] s, input logic f, input logic r,
                                input logic [19:0] bus);
      @(negedge clk);
      inValid  = v;
      sel      = s;
      flush    = f;
      outReady = r;
      inBus    = bus;
   endtask

   // Stage contents evolve as a FIFO: pop on transfer, push on accept when fewer than two held.
   always @(posedge clk) begin
      int n;
      bit acc;
      bit xfer;
      if (rst) begin
         q.delete();
         modelLive = 1;
         zeroData = 1;
         zeroPar = 1;
      end else if (modelLive) begin
         if (flush) begin
            q.delete();
            zeroPar = 1;
         end else begin
            n = q.size();
            acc = inValid && (n < 2);
            xfer = (n > 0) && outReady;
            if (xfer) void'(q.pop_front());
            if (acc) begin
               q.push_back('{bus: inBus, s: sel});
               zeroData = 0;
               zeroPar = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("in_ready4", 32'(inReady4), 32'(q.size() < 2));
         checkOutput("in_ready3", 32'(inReady3), 32'(q.size() < 2));
         checkOutput("out_valid4", 32'(outValid4), 32'(q.size() > 0));
         checkOutput("out_valid3", 32'(outValid3), 32'(q.size() > 0));
         if (q.size() > 0) begin
            checkOutput("out_data4", 32'(outData4), 32'(pick(q[0].bus, q[0].s, 4)));
            checkOutput("out_err4", 32'(outErr4), 32'd0);
            checkOutput("out_data3", 32'(outData3), 32'(pick(q[0].bus, q[0].s, 3)));
            checkOutput("out_err3", 32'(outErr3), 32'(q[0].s == 2'd3));
`ifdef SEL_MUX_PIPE_PARITY_EN
            checkOutput("out_par4", 32'(outPar4), 32'(^pick(q[0].bus, q[0].s, 4)));
            checkOutput("out_par3", 32'(outPar3), 32'(^pick(q[0].bus, q[0].s, 3)));
`endif
         end else begin
            if (zeroData) begin
               checkOutput("idle_data4", 32'(outData4), 32'd0);
               checkOutput("idle_err3", 32'(outErr3), 32'd0);
            end
`ifdef SEL_MUX_PIPE_PARITY_EN
            if (zeroPar) checkOutput("idle_par4", 32'(outPar4), 32'd0);
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      inValid = 1'b0;
      sel = 2'd0;
      flush = 1'b0;
      outReady = 1'b1;
      inBus = LANES;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("lit_reset_valid", 32'(outValid4), 32'd0);
      checkOutput("lit_reset_data", 32'(outData4), 32'd0);
      checkOutput("lit_reset_ready", 32'(inReady4), 32'd1);

      applyStimulus(1, 2'd1, 0, 1, LANES);
      applyStimulus(1, 2'd0, 0, 1, LANES);
      checkOutput("lit_sel1_data", 32'(outData4), 32'd7);
      checkOutput("lit_sel1_valid", 32'(outValid4), 32'd1);
      checkOutput("lit_sel1_err", 32'(outErr4), 32'd0);
`ifdef SEL_MUX_PIPE_PARITY_EN
      checkOutput("lit_sel1_par", 32'(outPar4), 32'd1);
`endif
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_sel0_data", 32'(outData4), 32'd5);

      applyStimulus(1, 2'd0, 0, 1, LANES);
      applyStimulus(1, 2'd1, 0, 1, LANES);
      checkOutput("lit_stream0", 32'(outData4), 32'd5);
      applyStimulus(1, 2'd2, 0, 1, LANES);
      checkOutput("lit_stream1", 32'(outData4), 32'd7);
      checkOutput("lit_stream_ready", 32'(inReady4), 32'd1);
      applyStimulus(1, 2'd3, 0, 1, LANES);
      checkOutput("lit_stream2", 32'(outData4), 32'd9);
      applyStimulus(1, 2'd2, 0, 0, LANES);
      checkOutput("lit_stream3", 32'(outData4), 32'd31);
      applyStimulus(0, 2'd0, 0, 0, LANES);
      checkOutput("lit_skid_ready", 32'(inReady4), 32'd0);
      checkOutput("lit_skid_hold", 32'(outData4), 32'd31);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_skid_hold2", 32'(outData4), 32'd31);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_skid_next", 32'(outData4), 32'd9);
      checkOutput("lit_skid_ready_back", 32'(inReady4), 32'd1);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_drained", 32'(outValid4), 32'd0);

      applyStimulus(1, 2'd3, 0, 1, LANES);
      applyStimulus(1, 2'd2, 0, 1, LANES);
      checkOutput("lit_oor_data", 32'(outData3), 32'd0);
      checkOutput("lit_oor_err", 32'(outErr3), 32'd1);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_inrange_data", 32'(outData3), 32'd9);
      checkOutput("lit_inrange_err", 32'(outErr3), 32'd0);

      applyStimulus(1, 2'd1, 0, 0, LANES);
      applyStimulus(1, 2'd2, 0, 0, LANES);
      applyStimulus(1, 2'd3, 1, 0, LANES);
      checkOutput("lit_full_ready", 32'(inReady4), 32'd0);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_flush_valid", 32'(outValid4), 32'd0);
      checkOutput("lit_flush_ready", 32'(inReady4), 32'd1);
      applyStimulus(0, 2'd0, 0, 1, LANES);
      checkOutput("lit_flush_dropped", 32'(outValid4), 32'd0);

      applyStimulus(1, 2'd1, 0, 0, LANES);
      applyStimulus(1, 2'd2, 0, 0, LANES);
      applyStimulus(0, 2'd0, 0, 0, LANES);
      checkOutput("lit_mid_full", 32'(inReady4), 32'd0);
`ifdef SEL_MUX_PIPE_PARITY_EN
      checkOutput("lit_mid_par", 32'(outPar4), 32'd1);
`endif
      rst = 1'b1;
      @(negedge clk);
      checkOutput("lit_mid_valid", 32'(outValid4), 32'd0);
      checkOutput("lit_mid_data", 32'(outData4), 32'd0);
      checkOutput("lit_mid_err", 32'(outErr4), 32'd0);
      checkOutput("lit_mid_ready", 32'(inReady4), 32'd1);
`ifdef SEL_MUX_PIPE_PARITY_EN
      checkOutput("lit_mid_par_rst", 32'(outPar4), 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 31) == 0), ($urandom_range(0, 4) < 3),
                       20'($urandom));
         rst = ($urandom_range(0, 199) == 0);
      end
      applyStimulus(0, 2'd0, 0, 1, LANES);
      rst = 1'b0;
      repeat (3) applyStimulus(0, 2'd0, 0, 1, LANES);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
